// File: rtl/uart_tx_fifo_if.sv
// Signal bundle between the bus write path, uart_tx_fifo and the UART transmitter.
// master = surrounding bus/transmitter side, slave = the FIFO itself.
interface uart_tx_fifo_if #(
    parameter int unsigned DEPTH_LOG2 = 4
);
    logic                push;
    logic [7:0]          push_data;
    logic                flush;
    logic                clr_ovf;
    logic                tx_avai;
    logic                tx_start;
    logic [7:0]          tx_data;
    logic                full;
    logic                empty;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;
    logic                irq;

    modport master (
        output push, push_data, flush, clr_ovf, tx_avai,
        input  tx_start, tx_data, full, empty, count, overflow, irq
    );

    modport slave (
        input  push, push_data, flush, clr_ovf, tx_avai,
        output tx_start, tx_data, full, empty, count, overflow, irq
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte transmit FIFO with a drain FSM feeding the UART transmitter via tx_start/tx_avai.
// Optional drain-complete interrupt built only when UART_TXFIFO_IRQ_EN is defined.
module uart_tx_fifo #(
    parameter int unsigned DEPTH_LOG2  = 4,
    parameter int unsigned ACK_TIMEOUT = 4
) (
    input logic           clk,
    input logic           reset,
    uart_tx_fifo_if.slave bus
);
    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam int unsigned AckW  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StStart, StAck, StDrain} state_e;

    state_e                state_q, state_d;
    logic [7:0]            mem_q [Depth];
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [AckW-1:0]       ack_cnt_q, ack_cnt_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  overflow_q, overflow_d;
    logic                  full, empty, pop, push_ok, drop;

    assign full  = (count_q == (DEPTH_LOG2 + 1)'(Depth));
    assign empty = (count_q == '0);

    // Datapath: pointers, occupancy, output byte and sticky overflow.
    always_comb begin
        pop        = (state_q == StIdle) && !empty && bus.tx_avai;
        push_ok    = bus.push && !bus.flush && (!full || pop);
        drop       = bus.push && !bus.flush && full && !pop;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        tx_data_d  = tx_data_q;
        overflow_d = drop | (overflow_q & ~bus.clr_ovf);

        if (push_ok) begin
            wptr_d = wptr_q + DEPTH_LOG2'(1);
        end
        if (pop) begin
            tx_data_d = mem_q[rptr_q];
        end

        // Flush empties the queue but leaves an already popped byte in flight.
        if (bus.flush) begin
            rptr_d  = wptr_q;
            count_d = '0;
        end else begin
            if (pop) begin
                rptr_d = rptr_q + DEPTH_LOG2'(1);
            end
            if (push_ok && !pop) begin
                count_d = count_q + (DEPTH_LOG2 + 1)'(1);
            end else if (pop && !push_ok) begin
                count_d = count_q - (DEPTH_LOG2 + 1)'(1);
            end
        end
    end

    // Drain FSM next state.
    always_comb begin
        state_d   = state_q;
        ack_cnt_d = '0;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                state_d = StAck;
            end
            StAck: begin
                // A transmitter that never drops tx_avai is treated as having accepted.
                if (!bus.tx_avai || (ack_cnt_q == AckW'(ACK_TIMEOUT - 1))) begin
                    state_d = StDrain;
                end else begin
                    ack_cnt_d = ack_cnt_q + AckW'(1);
                end
            end
            StDrain: begin
                if (bus.tx_avai) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            ack_cnt_q  <= '0;
            tx_data_q  <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            ack_cnt_q  <= ack_cnt_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= bus.push_data;
        end
    end

    assign bus.tx_start = (state_q == StStart);
    assign bus.tx_data  = tx_data_q;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;

`ifdef UART_TXFIFO_IRQ_EN
    logic irq_q;

    // Built from next-state values so irq lines up with empty/IDLE as seen on the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (count_d == '0) && (state_d == StIdle);
        end
    end

    assign bus.irq = irq_q;
`else
    assign bus.irq = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo with a simple transmitter model.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int unsigned DepthLog2 = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DEPTH_LOG2(DepthLog2)) bus ();

    uart_tx_fifo #(
        .DEPTH_LOG2  (DepthLog2),
        .ACK_TIMEOUT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         checks = 0;
    int         fails  = 0;
    int         cyc    = 0;
    logic       model_on   = 1'b0;
    logic       model_hold = 1'b0;
    logic       model_avai = 1'b1;
    logic       tb_avai    = 1'b0;
    int         busy_len   = 3;
    int         busy       = 0;
    logic [7:0] sent_q[$];
    int         start_cyc[$];
    int         consec     = 0;
    logic       prev_start = 1'b0;
    logic       exp_irq;

    assign bus.tx_avai = model_on ? model_avai : tb_avai;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: logs every start, then goes busy for busy_len cycles.
    always @(negedge clk) begin
        if (bus.tx_start) begin
            sent_q.push_back(bus.tx_data);
            start_cyc.push_back(cyc);
            if (prev_start) consec++;
        end
        if (!model_on) begin
            model_avai = 1'b1;
            busy       = 0;
        end else if (bus.tx_start && !model_hold) begin
            model_avai = 1'b0;
            busy       = busy_len;
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) model_avai = 1'b1;
        end
        prev_start = bus.tx_start;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_bytes(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            bus.push      = 1'b1;
            bus.push_data = first + 8'(i);
            @(negedge clk);
        end
        bus.push = 1'b0;
    endtask

    task automatic wait_starts(input int target, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (sent_q.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        checks++; if (bus.count !== 5'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        checks++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b expected 0", bus.full); end
        checks++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b expected 0", bus.overflow); end
        checks++; if (bus.tx_start !== 1'b0) begin fails++; $display("FAIL reset_start: got %b expected 0", bus.tx_start); end
        checks++; if (bus.tx_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", bus.tx_data); end
        checks++; if (bus.irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b expected 0", bus.irq); end
        reset = 1'b0;
        tick(2);
        checks++; if (bus.irq !== exp_irq) begin fails++; $display("FAIL idle_irq: got %b expected %b", bus.irq, exp_irq); end
    endtask

    task automatic test_single_byte();
        int base;
        base     = sent_q.size();
        busy_len = 3;
        model_on = 1'b1;
        tick(1);
        bus.push      = 1'b1;
        bus.push_data = 8'h41;
        @(negedge clk);
        bus.push = 1'b0;
        checks++; if (bus.count !== 5'd1) begin fails++; $display("FAIL single_count1: got %0d expected 1", bus.count); end
        checks++; if (bus.tx_start !== 1'b0) begin fails++; $display("FAIL single_early: got %b expected 0", bus.tx_start); end
        checks++; if (bus.irq !== 1'b0) begin fails++; $display("FAIL single_irq_low: got %b expected 0", bus.irq); end
        @(negedge clk);
        checks++; if (bus.tx_start !== 1'b1) begin fails++; $display("FAIL single_start: got %b expected 1", bus.tx_start); end
        checks++; if (bus.tx_data !== 8'h41) begin fails++; $display("FAIL single_data: got %h expected 41", bus.tx_data); end
        tick(4);
        checks++; if (bus.count !== 5'd0) begin fails++; $display("FAIL single_count0: got %0d expected 0", bus.count); end
        checks++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL single_empty: got %b expected 1", bus.empty); end
        checks++; if (bus.irq !== exp_irq) begin fails++; $display("FAIL single_irq: got %b expected %b", bus.irq, exp_irq); end
        checks++; if (bus.tx_data !== 8'h41) begin fails++; $display("FAIL single_hold: got %h expected 41", bus.tx_data); end
        checks++; if (sent_q.size() - base !== 1) begin fails++; $display("FAIL single_nsent: got %0d expected 1", sent_q.size() - base); end
    endtask

    task automatic test_fill_overflow();
        int base;
        bit ok;
        model_on = 1'b0;
        tb_avai  = 1'b0;
        base     = sent_q.size();
        push_bytes(8'h00, 17);
        checks++; if (bus.full !== 1'b1) begin fails++; $display("FAIL fill_full: got %b expected 1", bus.full); end
        checks++; if (bus.count !== 5'd16) begin fails++; $display("FAIL fill_count: got %0d expected 16", bus.count); end
        checks++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL fill_ovf: got %b expected 1", bus.overflow); end
        checks++; if (bus.irq !== 1'b0) begin fails++; $display("FAIL fill_irq: got %b expected 0", bus.irq); end
        // Clear and a fresh drop in the same cycle: the drop must win.
        bus.push      = 1'b1;
        bus.push_data = 8'h11;
        bus.clr_ovf   = 1'b1;
        @(negedge clk);
        bus.push = 1'b0;
        checks++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL ovf_set_wins: got %b expected 1", bus.overflow); end
        @(negedge clk);
        bus.clr_ovf = 1'b0;
        checks++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %b expected 0", bus.overflow); end
        model_on = 1'b1;
        wait_starts(base + 16, 300, ok);
        tick(20);
        checks++; if (ok !== 1'b1) begin fails++; $display("FAIL fill_drain_timeout: got %b expected 1", ok); end
        checks++; if (sent_q.size() - base !== 16) begin fails++; $display("FAIL fill_nsent: got %0d expected 16", sent_q.size() - base); end
        for (int i = 0; i < 16 && base + i < sent_q.size(); i++) begin
            checks++;
            if (sent_q[base + i] !== 8'(i)) begin
                fails++; $display("FAIL fill_order[%0d]: got %h expected %h", i, sent_q[base + i], 8'(i));
            end
        end
        checks++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL fill_empty: got %b expected 1", bus.empty); end
    endtask

    task automatic test_push_pop_full();
        int base;
        bit ok;
        model_on = 1'b0;
        tb_avai  = 1'b0;
        base     = sent_q.size();
        push_bytes(8'h20, 16);
        checks++; if (bus.count !== 5'd16) begin fails++; $display("FAIL ppf_fill: got %0d expected 16", bus.count); end
        model_on      = 1'b1;
        bus.push      = 1'b1;
        bus.push_data = 8'hAA;
        @(negedge clk);
        bus.push = 1'b0;
        checks++; if (bus.count !== 5'd16) begin fails++; $display("FAIL ppf_count: got %0d expected 16", bus.count); end
        checks++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL ppf_ovf: got %b expected 0", bus.overflow); end
        checks++; if (bus.tx_data !== 8'h20) begin fails++; $display("FAIL ppf_first: got %h expected 20", bus.tx_data); end
        wait_starts(base + 17, 300, ok);
        tick(20);
        checks++; if (ok !== 1'b1) begin fails++; $display("FAIL ppf_timeout: got %b expected 1", ok); end
        checks++; if (sent_q.size() - base !== 17) begin fails++; $display("FAIL ppf_nsent: got %0d expected 17", sent_q.size() - base); end
        if (sent_q.size() >= base + 17) begin
            checks++; if (sent_q[base + 15] !== 8'h2F) begin fails++; $display("FAIL ppf_16th: got %h expected 2f", sent_q[base + 15]); end
            checks++; if (sent_q[base + 16] !== 8'hAA) begin fails++; $display("FAIL ppf_last: got %h expected aa", sent_q[base + 16]); end
        end
    endtask

    task automatic test_flush();
        int base;
        bit seen;
        model_on = 1'b0;
        tb_avai  = 1'b0;
        base     = sent_q.size();
        push_bytes(8'h50, 5);
        checks++; if (bus.count !== 5'd5) begin fails++; $display("FAIL flush_fill: got %0d expected 5", bus.count); end
        model_on = 1'b1;
        seen     = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.tx_start;
        end
        checks++; if (seen !== 1'b1) begin fails++; $display("FAIL flush_start_timeout: got %b expected 1", seen); end
        tick(2);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        checks++; if (bus.count !== 5'd0) begin fails++; $display("FAIL flush_count: got %0d expected 0", bus.count); end
        checks++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL flush_empty: got %b expected 1", bus.empty); end
        tick(20);
        checks++; if (sent_q.size() - base !== 1) begin fails++; $display("FAIL flush_nsent: got %0d expected 1", sent_q.size() - base); end
        checks++; if (bus.tx_data !== 8'h50) begin fails++; $display("FAIL flush_data: got %h expected 50", bus.tx_data); end
    endtask

    task automatic test_ack_timeout();
        int base;
        bit ok;
        model_on = 1'b0;
        tb_avai  = 1'b0;
        base     = sent_q.size();
        push_bytes(8'h61, 2);
        model_hold = 1'b1;
        model_on   = 1'b1;
        wait_starts(base + 2, 60, ok);
        tick(12);
        model_hold = 1'b0;
        checks++; if (ok !== 1'b1) begin fails++; $display("FAIL ackto_timeout: got %b expected 1", ok); end
        checks++; if (sent_q.size() - base !== 2) begin fails++; $display("FAIL ackto_nsent: got %0d expected 2", sent_q.size() - base); end
        if (sent_q.size() >= base + 2) begin
            checks++; if (sent_q[base] !== 8'h61) begin fails++; $display("FAIL ackto_b0: got %h expected 61", sent_q[base]); end
            checks++; if (sent_q[base + 1] !== 8'h62) begin fails++; $display("FAIL ackto_b1: got %h expected 62", sent_q[base + 1]); end
            // START + 4 ACK + DRAIN + IDLE
            checks++;
            if (start_cyc[base + 1] - start_cyc[base] !== 7) begin
                fails++; $display("FAIL ackto_spacing: got %0d expected 7", start_cyc[base + 1] - start_cyc[base]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int base;
        bit ok;
        model_on = 1'b0;
        tb_avai  = 1'b0;
        busy_len = 2;
        base     = sent_q.size();
        push_bytes(8'h81, 3);
        model_on = 1'b1;
        wait_starts(base + 3, 60, ok);
        tick(12);
        busy_len = 3;
        checks++; if (ok !== 1'b1) begin fails++; $display("FAIL b2b_timeout: got %b expected 1", ok); end
        for (int i = 0; i < 3 && base + i < sent_q.size(); i++) begin
            checks++;
            if (sent_q[base + i] !== 8'h81 + 8'(i)) begin
                fails++; $display("FAIL b2b_order[%0d]: got %h expected %h", i, sent_q[base + i], 8'h81 + 8'(i));
            end
            if (i > 0) begin
                checks++;
                if (start_cyc[base + i] - start_cyc[base + i - 1] !== 4) begin
                    fails++; $display("FAIL b2b_spacing[%0d]: got %0d expected 4", i, start_cyc[base + i] - start_cyc[base + i - 1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        bit seen;
        bit ok;
        model_on = 1'b0;
        tb_avai  = 1'b0;
        base     = sent_q.size();
        push_bytes(8'h71, 3);
        model_hold = 1'b1;
        model_on   = 1'b1;
        seen       = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.tx_start;
        end
        checks++; if (seen !== 1'b1) begin fails++; $display("FAIL rmid_start_timeout: got %b expected 1", seen); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.count !== 5'd0) begin fails++; $display("FAIL rmid_count: got %0d expected 0", bus.count); end
        checks++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL rmid_empty: got %b expected 1", bus.empty); end
        checks++; if (bus.tx_start !== 1'b0) begin fails++; $display("FAIL rmid_start: got %b expected 0", bus.tx_start); end
        checks++; if (bus.tx_data !== 8'h00) begin fails++; $display("FAIL rmid_data: got %h expected 00", bus.tx_data); end
        checks++; if (bus.irq !== 1'b0) begin fails++; $display("FAIL rmid_irq: got %b expected 0", bus.irq); end
        reset = 1'b0;
        tick(15);
        model_hold = 1'b0;
        checks++; if (sent_q.size() - base !== 1) begin fails++; $display("FAIL rmid_quiet: got %0d expected 1", sent_q.size() - base); end
        push_bytes(8'h7A, 1);
        wait_starts(base + 2, 20, ok);
        tick(12);
        checks++; if (ok !== 1'b1) begin fails++; $display("FAIL rmid_new_timeout: got %b expected 1", ok); end
        if (sent_q.size() >= base + 2) begin
            checks++; if (sent_q[base + 1] !== 8'h7A) begin fails++; $display("FAIL rmid_new: got %h expected 7a", sent_q[base + 1]); end
        end
    endtask

    initial begin
`ifdef UART_TXFIFO_IRQ_EN
        exp_irq = 1'b1;
`else
        exp_irq = 1'b0;
`endif
        bus.push      = 1'b0;
        bus.push_data = 8'h00;
        bus.flush     = 1'b0;
        bus.clr_ovf   = 1'b0;
        test_reset();
        test_single_byte();
        test_fill_overflow();
        test_push_pop_full();
        test_flush();
        test_ack_timeout();
        test_back_to_back();
        test_reset_mid();
        checks++; if (consec !== 0) begin fails++; $display("FAIL start_consecutive: got %0d expected 0", consec); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte-wide transmit FIFO between the CPU bus write path and the UART transmitter. Bus writes to the UART data offset push bytes here, so software does not have to poll line status before every byte. A drain state machine pops one byte at a time into the transmitter through its `tx_start`/`tx_avai` handshake and holds `tx_data` stable until the next pop. Bus-readable status is exported for the line status register and interrupt logic.

## Interface
- `DEPTH_LOG2`, default 4: FIFO holds 2^DEPTH_LOG2 bytes (16).
- `ACK_TIMEOUT`, default 4: cycles to wait in ACK for `tx_avai` to fall.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `push`  in  1  write strobe (bus STB && WE && data offset); one byte per cycle.
- `push_data`  in  8  byte to enqueue.
- `flush`  in  1  discards all queued bytes; an in-flight byte is unaffected.
- `clr_ovf`  in  1  clears the `overflow` flag.
- `tx_avai`  in  1  transmitter idle, from the transmitter.
- `tx_start`  out  1  one-cycle start pulse to the transmitter.
- `tx_data`  out  8  byte presented to the transmitter; registered.
- `full`  out  1  count == 2^DEPTH_LOG2.
- `empty`  out  1  count == 0.
- `count`  out  DEPTH_LOG2+1  number of queued bytes.
- `overflow`  out  1  sticky flag: a push was dropped.
- `irq`  out  1  drain-complete interrupt; see Configuration.

## Operation
- Storage is a circular buffer of 2^DEPTH_LOG2 × 8 register words, with `wptr`/`rptr` of DEPTH_LOG2 bits that wrap modulo depth and a separate `count` register.
- **Push.** Accepted when `!full`, or when `full` and a pop occurs in the same cycle. A push while `full` with no pop drops the byte and sets `overflow`.
- **Pop.** Occurs only on the IDLE→START transition. `tx_data` loads `mem[rptr]`, `rptr` increments, and `count` decrements. Push and pop in the same cycle leave `count` unchanged.
- **Flush.** `count` := 0 and `rptr` := `wptr`. Flush has priority over a same-cycle push; that byte is dropped without setting `overflow`.
- **Overflow flag.** `clr_ovf` clears `overflow`. If clear and a new drop happen in the same cycle, the set wins.
- **Drain FSM.**
  - IDLE: go to START when `count != 0` and `tx_avai` (pop happens here).
  - START: `tx_start` = 1 for exactly this cycle; go to ACK unconditionally.
  - ACK: go to DRAIN when `tx_avai == 0`, or after ACK_TIMEOUT cycles in ACK with `tx_avai` still 1 (treat as accepted).
  - DRAIN: go to IDLE when `tx_avai == 1`.
- `tx_data` changes only on a pop. It holds its value from START until the next pop.
- **Reset.** Pointers and `count` 0, state IDLE, `tx_start` 0, `tx_data` 8'h00, `overflow` 0, `irq` 0. Reset mid-transfer abandons the queued and in-flight bytes.

## Timing
- **Latency.** A push in cycle N into an empty FIFO, with IDLE and `tx_avai`=1, gives `count`=1 in cycle N+1 and `tx_start`=1 with valid `tx_data` in cycle N+2.
- `full`, `empty` and `count` are registered and reflect pushes/pops from the previous edge.
- **Back-to-back bytes.** Minimum spacing between `tx_start` pulses is 4 cycles: START, ACK, DRAIN, IDLE. In practice it is bounded by the transmitter frame time.
- `tx_start` is never high for two consecutive cycles.
- `tx_start` is never asserted while `tx_avai` was 0 at the IDLE decision edge.

## Configuration
- `UART_TXFIFO_IRQ_EN` defined: `irq` is a registered level, 1 when `empty` and state == IDLE (queue fully drained to the transmitter). It deasserts the cycle after the next accepted push.
- `UART_TXFIFO_IRQ_EN` undefined: `irq` is tied to 0 and the drain-complete logic is not built.

## Test plan
- **Single byte.** Push 8'h41 at idle with `tx_avai`=1 → `tx_start` pulses 2 cycles later with `tx_data`=8'h41. Transmitter model drops `tx_avai` → `count`=0, `empty`=1; `irq`=1 after return to IDLE when `UART_TXFIFO_IRQ_EN` is defined.
- **Fill and overflow.** With `tx_avai` held 0, push 17 bytes 8'h00..8'h10 → `full`=1, `count`=16, `overflow`=1. Release `tx_avai` → exactly 16 `tx_start` pulses with bytes 8'h00..8'h0F in order; 8'h10 is never sent.
- **Push/pop on full.** At `count`=16, push 8'hAA in the same cycle as a pop → `count` stays 16, no `overflow`; 8'hAA is emitted last.
- **Flush.** Queue 5 bytes, assert `flush` during DRAIN of byte 1 → byte 1 completes, `count`=0 next cycle, no further `tx_start`.
- **ACK timeout.** Transmitter model keeps `tx_avai`=1 after `tx_start` → FSM leaves ACK after 4 cycles and passes through DRAIN; the next byte's `tx_start` occurs and no byte is lost or duplicated.
- **Reset mid-transfer.** Queue 3 bytes, assert `reset` in ACK → all outputs return to reset values the next cycle; no `tx_start` until a new push.
